// File: rtl/aib_txfifo_rd_ctrl_dpath.sv
// TX adapter FIFO read side: word pointer, one-hot AND-OR read mux, output register,
// empty/underflow/flush. Define AIB_TXFIFO_RD_PIPE_EN to add a second output stage.
module aib_txfifo_rd_ctrl_dpath #(
  parameter int DOUTW = 80,
  parameter int RATIO = 4,
  parameter int DEPTH = 16,
  parameter int EPW   = $clog2(DEPTH),
  parameter int WPW   = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                                 rd_clk,
  input  logic                                 rd_rst,
  input  logic [DEPTH-1:0][DOUTW*RATIO-1:0]    fifo_data_async,
  input  logic [EPW:0]                         wr_ptr_sync,
  input  logic                                 rd_en,
  input  logic                                 rd_flush,
  input  logic [1:0]                           rd_ratio_sel,
  output logic [DOUTW-1:0]                     rdata_sync_ff,
  output logic                                 rd_dv,
  output logic                                 rd_empty,
  output logic                                 rd_uflow,
  output logic [EPW:0]                         rd_ptr_sync
);

  localparam int RLOG   = $clog2(RATIO);
  localparam int NWORDS = DEPTH * RATIO;
  localparam int SW     = EPW + WPW;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [EPW:0]           ent_ptr_q, ent_ptr_d;
  logic [WPW-1:0]         wrd_idx_q, wrd_idx_d;
  logic [1:0]             ratio_q, ratio_d;
  logic                   uflow_q, uflow_d;
  logic                   pop;
  logic                   last_word;
  logic                   empty;
  logic [SW-1:0]          sel_idx;
  logic [NWORDS-1:0]      word_oh;
  logic [DOUTW-1:0]       rd_mux;
  logic [DOUTW-1:0]       rdata_p0_q, rdata_p0_d;
  logic                   vld_p0_q, vld_p0_d;

  // Narrow modes cannot use more shifts than the entry has words.
  function automatic logic [1:0] map_ratio(input logic [1:0] sel);
    logic [1:0] s;
    s = (sel == 2'd3) ? 2'd0 : sel;
    if (int'(s) > RLOG) s = 2'(RLOG);
    return s;
  endfunction

  assign empty     = (ent_ptr_q == wr_ptr_sync);
  assign last_word = (int'(wrd_idx_q) == ((RATIO >> ratio_q) - 1));
  assign sel_idx   = (SW'(ent_ptr_q[EPW-1:0]) << RLOG) | SW'(wrd_idx_q);

  always_comb begin
    word_oh = '0;
    for (int i = 0; i < NWORDS; i++) word_oh[i] = (sel_idx == SW'(i));
  end

  always_comb begin
    rd_mux = '0;
    for (int e = 0; e < DEPTH; e++)
      for (int w = 0; w < RATIO; w++)
        rd_mux = rd_mux | (fifo_data_async[e][w*DOUTW +: DOUTW] & {DOUTW{word_oh[e*RATIO+w]}});
  end

  always_comb begin
    state_d   = state_q;
    ent_ptr_d = ent_ptr_q;
    wrd_idx_d = wrd_idx_q;
    ratio_d   = ratio_q;
    uflow_d   = uflow_q;
    pop       = 1'b0;
    if (rd_flush) begin
      ent_ptr_d = wr_ptr_sync;
      wrd_idx_d = '0;
      uflow_d   = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          ratio_d = map_ratio(rd_ratio_sel);
          if (rd_en && !empty) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (!rd_en) begin
            state_d = IDLE;
          end else if (empty) begin
            uflow_d = 1'b1;
          end else begin
            pop = 1'b1;
            if (last_word) begin
              wrd_idx_d = '0;
              ent_ptr_d = ent_ptr_q + 1'b1;
            end else begin
              wrd_idx_d = wrd_idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0: first output register
  assign vld_p0_d   = pop;
  assign rdata_p0_d = pop ? rd_mux : rdata_p0_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      ent_ptr_q  <= '0;
      wrd_idx_q  <= '0;
      ratio_q    <= 2'd0;
      uflow_q    <= 1'b0;
      vld_p0_q   <= 1'b0;
      rdata_p0_q <= '0;
    end else begin
      state_q    <= state_d;
      ent_ptr_q  <= ent_ptr_d;
      wrd_idx_q  <= wrd_idx_d;
      ratio_q    <= ratio_d;
      uflow_q    <= uflow_d;
      vld_p0_q   <= vld_p0_d;
      rdata_p0_q <= rdata_p0_d;
    end
  end

`ifdef AIB_TXFIFO_RD_PIPE_EN
  logic [DOUTW-1:0] rdata_p1_q, rdata_p1_d;
  logic             vld_p1_q, vld_p1_d;

  // Stage p1: retiming register; a flush drops the word still in p0
  assign vld_p1_d   = vld_p0_q & ~rd_flush;
  assign rdata_p1_d = vld_p1_d ? rdata_p0_q : rdata_p1_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      vld_p1_q   <= 1'b0;
      rdata_p1_q <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      rdata_p1_q <= rdata_p1_d;
    end
  end

  assign rdata_sync_ff = rdata_p1_q;
  assign rd_dv         = vld_p1_q;
`else
  assign rdata_sync_ff = rdata_p0_q;
  assign rd_dv         = vld_p0_q;
`endif

  assign rd_empty    = empty;
  assign rd_uflow    = uflow_q;
  assign rd_ptr_sync = ent_ptr_q;

endmodule

// File: tb/tb_aib_txfifo_rd_ctrl_dpath.sv
// Directed bench for aib_txfifo_rd_ctrl_dpath: expected-word scoreboard plus literal checks
// of pointers, flags and reset values.
module tb_aib_txfifo_rd_ctrl_dpath;
  localparam int DOUTW = 80;
  localparam int RATIO = 4;
  localparam int DEPTH = 16;
  localparam int EPW   = 4;
`ifdef AIB_TXFIFO_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                              clk = 1'b0;
  logic                              rd_rst = 1'b1;
  logic [DEPTH-1:0][DOUTW*RATIO-1:0] fifo_data;
  logic [EPW:0]                      wr_ptr = '0;
  logic                              rd_en = 1'b0;
  logic                              rd_flush = 1'b0;
  logic [1:0]                        rd_sel = 2'd0;
  logic [DOUTW-1:0]                  rdata;
  logic                              rd_dv;
  logic                              rd_empty;
  logic                              rd_uflow;
  logic [EPW:0]                      rd_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DOUTW-1:0] exp_q[$];
  logic [DOUTW-1:0] last_v = '0;
  logic [DOUTW-1:0] exp_w;
  logic             rst_at_edge = 1'b0;
  logic             armed = 1'b0;

  always #5 clk = ~clk;

  aib_txfifo_rd_ctrl_dpath #(.DOUTW(DOUTW), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .rd_clk          (clk),
    .rd_rst          (rd_rst),
    .fifo_data_async (fifo_data),
    .wr_ptr_sync     (wr_ptr),
    .rd_en           (rd_en),
    .rd_flush        (rd_flush),
    .rd_ratio_sel    (rd_sel),
    .rdata_sync_ff   (rdata),
    .rd_dv           (rd_dv),
    .rd_empty        (rd_empty),
    .rd_uflow        (rd_uflow),
    .rd_ptr_sync     (rd_ptr)
  );

  function automatic logic [DOUTW-1:0] word_val(input int e, input int w);
    return {8'(e), 8'(w), 64'h0123456789ABCDEF ^ 64'(e * 8 + w)};
  endfunction

  function automatic int shift_of(input logic [1:0] sel);
    return (sel == 2'd3) ? 0 : int'(sel);
  endfunction

  task automatic chk(input string name, input logic [DOUTW-1:0] act, input logic [DOUTW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: each entry yields its first RATIO>>shift words in order.
  task automatic expect_entries(input int first_ent, input int n_ent, input logic [1:0] sel);
    for (int k = 0; k < n_ent; k++)
      for (int w = 0; w < (RATIO >> shift_of(sel)); w++)
        exp_q.push_back(word_val((first_ent + k) % DEPTH, w));
  endtask

  task automatic drain(input string name);
    repeat (LAT + 2) tick();
    chk(name, 80'(exp_q.size()), 80'(0));
  endtask

  initial forever begin
    @(posedge clk);
    rst_at_edge = rd_rst;
    if (rd_rst) armed = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      if (rst_at_edge) begin
        chk("rst_rdata", rdata, 80'(0));
        chk("rst_dv", 80'(rd_dv), 80'(0));
        last_v = '0;
      end else if (rd_dv) begin
        if (exp_q.size() == 0) begin
          chk("dv_unexpected", 80'(rd_dv), 80'(0));
        end else begin
          exp_w = exp_q.pop_front();
          chk("rdata_word", rdata, exp_w);
          last_v = exp_w;
        end
      end else begin
        chk("rdata_hold", rdata, last_v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int e = 0; e < DEPTH; e++)
      for (int w = 0; w < RATIO; w++)
        fifo_data[e][w*DOUTW +: DOUTW] = word_val(e, w);

    // reset values
    repeat (3) tick();
    chk("reset_rdata", rdata, 80'(0));
    chk("reset_dv", 80'(rd_dv), 80'(0));
    chk("reset_uflow", 80'(rd_uflow), 80'(0));
    chk("reset_ptr", 80'(rd_ptr), 80'(0));
    chk("reset_empty", 80'(rd_empty), 80'(1));
    rd_rst = 1'b0;

    // full-width stream of entries 0,1
    wr_ptr = 5'd2; rd_sel = 2'd0; rd_en = 1'b1;
    expect_entries(0, 2, 2'd0);
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == LAT) chk("t1_first_dv_early", 80'(rd_dv), 80'(0));
      if (t == LAT + 1) begin
        chk("t1_first_dv", 80'(rd_dv), 80'(1));
        chk("t1_e0w0_literal", rdata, 80'h0000_0123456789ABCDEF);
      end
      if (t == 5) chk("t1_ptr_mid", 80'(rd_ptr), 80'(1));
    end
    rd_en = 1'b0;
    chk("t1_ptr_end", 80'(rd_ptr), 80'(2));
    chk("t1_empty", 80'(rd_empty), 80'(1));
    drain("t1_drained");
    chk("t1_no_uflow", 80'(rd_uflow), 80'(0));

    // half-width mode over entries 2..4
    wr_ptr = 5'd5; rd_sel = 2'd1; rd_en = 1'b1;
    expect_entries(2, 3, 2'd1);
    repeat (7) tick();
    rd_en = 1'b0;
    chk("t2_ptr", 80'(rd_ptr), 80'(5));
    chk("t2_empty", 80'(rd_empty), 80'(1));
    drain("t2_drained");

    // pointer wrap from entry 15 to entry 0 with wrap bit toggled
    wr_ptr = 5'd15; rd_flush = 1'b1;
    tick();
    rd_flush = 1'b0;
    chk("t3_flush_ptr", 80'(rd_ptr), 80'(15));
    wr_ptr = 5'd17; rd_sel = 2'd2; rd_en = 1'b1;
    expect_entries(15, 2, 2'd2);
    for (int t = 1; t <= 3; t++) begin
      tick();
      if (t == LAT + 1) chk("t3_e15w0_literal", rdata, 80'h0F00_0123456789ABCD97);
    end
    rd_en = 1'b0;
    chk("t3_ptr_wrap", 80'(rd_ptr), 80'(17));
    chk("t3_empty", 80'(rd_empty), 80'(1));
    drain("t3_drained");

    // underflow after the last available word, then cleared by flush
    wr_ptr = 5'd18; rd_sel = 2'd2; rd_en = 1'b1;
    expect_entries(1, 1, 2'd2);
    repeat (2) tick();
    chk("t4_empty_after_last", 80'(rd_empty), 80'(1));
    chk("t4_uflow_not_yet", 80'(rd_uflow), 80'(0));
    tick();
    chk("t4_uflow_set", 80'(rd_uflow), 80'(1));
    chk("t4_ptr_unchanged", 80'(rd_ptr), 80'(18));
    tick();
    chk("t4_uflow_dv", 80'(rd_dv), 80'(0));
    rd_en = 1'b0;
    tick();
    chk("t4_uflow_sticky", 80'(rd_uflow), 80'(1));
    rd_flush = 1'b1;
    tick();
    rd_flush = 1'b0;
    chk("t4_uflow_cleared", 80'(rd_uflow), 80'(0));
    drain("t4_drained");

    // flush mid-entry (word index 2) while rd_en is held
    wr_ptr = 5'd20; rd_sel = 2'd0; rd_en = 1'b1;
    exp_q.push_back(word_val(2, 0));
    if (LAT == 1) exp_q.push_back(word_val(2, 1));
    repeat (3) tick();
    rd_flush = 1'b1;
    tick();
    rd_flush = 1'b0;
    chk("t5_flush_ptr", 80'(rd_ptr), 80'(20));
    chk("t5_flush_dv", 80'(rd_dv), 80'(0));
    chk("t5_flush_empty", 80'(rd_empty), 80'(1));
    // restart from word 0 after a one-cycle activation; sel 3 means full width
    wr_ptr = 5'd21; rd_sel = 2'd3;
    expect_entries(4, 1, 2'd3);
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 4) chk("t5_ptr_before_last", 80'(rd_ptr), 80'(20));
    end
    rd_en = 1'b0;
    chk("t5_ptr_after", 80'(rd_ptr), 80'(21));
    drain("t5_drained");

    // reset during streaming
    wr_ptr = 5'd23; rd_sel = 2'd0; rd_en = 1'b1;
    exp_q.push_back(word_val(5, 0));
    if (LAT == 1) exp_q.push_back(word_val(5, 1));
    repeat (3) tick();
    rd_rst = 1'b1;
    tick();
    chk("t6_rst_rdata", rdata, 80'(0));
    chk("t6_rst_dv", 80'(rd_dv), 80'(0));
    chk("t6_rst_uflow", 80'(rd_uflow), 80'(0));
    chk("t6_rst_ptr", 80'(rd_ptr), 80'(0));
    chk("t6_rst_empty", 80'(rd_empty), 80'(0));
    rd_rst = 1'b0; rd_en = 1'b0;
    drain("t6_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
